uart_alu_intf: RTL

Command sequencer between the UART receiver and the UART transmitter. It assembles three received bytes into an ALU operation: operand A, then operand B, then the opcode. It drives the combinational ALU with those values, registers the ALU result and hands it to the transmitter as a single byte. Its input side consumes the receiver's done pulse and byte; its output side feeds the transmitter's start/byte inputs.

---
 rtl/uart_alu_intf_if.sv | 27 ++
 rtl/uart_alu_intf.sv | 77 +++++++
 2 files changed

// File: rtl/uart_alu_intf_if.sv
// Receiver/ALU/transmitter signal bundle for the command sequencer.
// master = sequencer side, slave = surrounding UART, ALU and bench.
interface uart_alu_intf_if #(
  parameter int BITS = 8,
  parameter int OP_W = 6
);
  logic            rx_done;
  logic [7:0]      rx_byte;
  logic [BITS-1:0] alu_result;
  logic            tx_done;
  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [OP_W-1:0] alu_op;
  logic [7:0]      tx_byte;
  logic            tx_start;
  logic            busy;

  modport master (
    input  rx_done, rx_byte, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_byte, tx_start, busy
  );

  modport slave (
    output rx_done, rx_byte, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_byte, tx_start, busy
  );
endinterface

// File: rtl/uart_alu_intf.sv
// Collects A, B, opcode bytes from the UART receiver, latches the ALU result and
// issues a one-cycle transmit request; start rises two edges after the opcode edge.
module uart_alu_intf #(
  parameter int BITS = 8,
  parameter int OP_W = 6
) (
  input  logic             i_Clock,
  input  logic             i_reset,
  uart_alu_intf_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state;
  logic   rx_d;
  logic   tx_d;
  logic   rx_evt;
  logic   tx_evt;
  logic   rx_hi_unused;

  // Done levels may be held many cycles; only the rising edge counts.
  assign rx_evt       = bus.rx_done & ~rx_d;
  assign tx_evt       = bus.tx_done & ~tx_d;
  assign rx_hi_unused = ^bus.rx_byte[7:OP_W];

  assign bus.busy = (state == CALC) || (state == SEND) || (state == WAIT_TX);

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= WAIT_A;
      rx_d         <= 1'b0;
      tx_d         <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_op   <= '0;
      bus.tx_byte  <= '0;
      bus.tx_start <= 1'b0;
    end else begin
      rx_d         <= bus.rx_done;
      tx_d         <= bus.tx_done;
      bus.tx_start <= 1'b0;
      case (state)
        WAIT_A: if (rx_evt) begin
          bus.alu_a <= bus.rx_byte;
          state     <= WAIT_B;
        end
        WAIT_B: if (rx_evt) begin
          bus.alu_b <= bus.rx_byte;
          state     <= WAIT_OP;
        end
        WAIT_OP: if (rx_evt) begin
          bus.alu_op <= bus.rx_byte[OP_W-1:0];
          state      <= CALC;
        end
        // One cycle for the external combinational ALU to settle on the new opcode.
        CALC: begin
          bus.tx_byte <= bus.alu_result[7:0];
          state       <= SEND;
        end
        SEND: begin
          bus.tx_start <= 1'b1;
          state        <= WAIT_TX;
        end
        WAIT_TX: if (tx_evt) state <= WAIT_A;
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule
